f36m_pow3_iter: RTL and testbench
=================================

F36M_POW3_ITER -- requirements
Module: f36m_pow3_iter

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the iteration-count input.
REQ-002 SHALL have parameter EN_INV, default 1: when 1, the mode input is honoured; when 0, mode is ignored and treated as 0.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request pulse, sampled only in IDLE.
REQ-006 SHALL have port mode  input  1  0 = forward Frobenius a^(3^n); 1 = reduced count (6m - n) mod 6m.
REQ-007 SHALL have port n  input  CNT_W  iteration count, sampled with start.
REQ-008 SHALL have port a  input  `W6+1  GF(3^{6m}) operand in the codebase element layout, sampled with start.
REQ-009 SHALL have port busy  output  1  high in states RUN and DONE.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the result becomes valid.
REQ-011 SHALL have port c  output  `W6+1  result register, held until the next accepted start.

Function
REQ-012 SHALL contain exactly one combinational GF(3^{6m}) cubing stage, functionally identical to the codebase f36m_cubic datapath, fed from the internal accumulator register.
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL, in IDLE with start=1, load the accumulator with a and the down-counter with the effective count k, then enter RUN if k>0, or DONE if k=0.
REQ-015 SHALL compute the effective count as k=n when mode=0. When mode=1, k = (6*97 - (n mod 582)) mod 582, computed in a counter wide enough to hold 581 regardless of CNT_W.
REQ-016 SHALL, in RUN on each cycle, replace the accumulator with its cube and decrement the counter; it leaves RUN for DONE on the cycle the counter reaches 0.
REQ-017 SHALL, in DONE, copy the accumulator to c, assert done for exactly that cycle, and return to IDLE on the next cycle.
REQ-018 SHALL produce done exactly k+1 cycles after the start-sampling edge; k=0 gives done on the first edge after acceptance.
REQ-019 SHALL ignore start, n, a and mode while busy=1; no queuing of requests.
REQ-020 SHALL accept start asserted in the same cycle that done is high only after the return to IDLE, i.e. one cycle later; a back-to-back request therefore costs one idle cycle.
REQ-021 SHALL keep c unchanged from DONE until the DONE state of the next accepted request; c does not change during RUN.
REQ-022 SHALL treat n=2^CNT_W-1 as a valid count, with no overflow or wrap of the counter.
REQ-023 SHALL produce no X on busy or done for any input values once reset is released.

Reset
REQ-024 SHALL, while reset=0 and independent of clk: set the state to IDLE, busy=0, done=0, c=0, and clear the accumulator and counter to 0.
REQ-025 SHALL, on reset asserted mid-RUN, abort the operation with no done pulse; c returns to 0.
REQ-026 SHALL, after reset release, accept start on the first rising edge.

Verification
REQ-027 SHALL pass this scenario: after reset, start with n=0, mode=0, a=A -> done on edge 1, c=A, busy high for 1 cycle.
REQ-028 SHALL pass this scenario: start with n=1, mode=0, a=A -> done on edge 2, c equal to the f36m_cubic output for input A.
REQ-029 SHALL pass this scenario: start with n=3, mode=0 -> done on edge 4, c = cube applied three times to A by the golden model. Also check that start pulses applied during cycles 1-3 are ignored and c is unchanged until done.
REQ-030 SHALL pass this scenario: mode=1, n=1 -> k=581; run forward n=1 on A and feed the result back with mode=1, n=1 -> the final c equals A (6m-fold Frobenius is the identity), with done 582 cycles after start.
REQ-031 SHALL pass this scenario: CNT_W=8, n=255, mode=0 -> done exactly 256 cycles after start, and c matches the golden model.
REQ-032 SHALL pass this scenario: start with n=10, then drive reset=0 at cycle 5 -> busy=0, done=0, c=0 immediately, and no done pulse occurs. A new start with n=0 after release gives done on edge 1.

Source files
------------

// File: rtl/f36m_pow3_iter.sv
// Iterated Frobenius in GF(3^{6m}), m=97: c = a^(3^k), one cube per cycle.
// Element layout: six GF(3^97) coefficients, two bits per trit, a0 lowest.
`ifndef W6
`define W6 1163
`endif

module f36m_pow3_iter #(
  parameter int CNT_W  = 8,
  parameter bit EN_INV = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] n,
  input  logic [`W6:0]     a,
  output logic             busy,
  output logic             done,
  output logic [`W6:0]     c
);

  localparam int M  = 97;
  localparam int BW = 2 * M;
  localparam int KW = (CNT_W > 10) ? CNT_W : 10;
  localparam logic [KW-1:0] K6M = KW'(6 * M);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [1:0] t_add(logic [1:0] x, logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  function automatic logic [1:0] t_neg(logic [1:0] x);
    return {x[0], x[1]};
  endfunction

  function automatic logic [BW-1:0] e_add(logic [BW-1:0] x,
                                          logic [BW-1:0] y);
    logic [BW-1:0] r;
    for (int i = 0; i < M; i++)
      r[2*i +: 2] = t_add(x[2*i +: 2], y[2*i +: 2]);
    return r;
  endfunction

  function automatic logic [BW-1:0] e_neg(logic [BW-1:0] x);
    logic [BW-1:0] r;
    for (int i = 0; i < M; i++)
      r[2*i +: 2] = t_neg(x[2*i +: 2]);
    return r;
  endfunction

  // Spread trits to degree 3i, then fold with x^97 = 2x^12 + 1.
  function automatic logic [BW-1:0] f3m_cube(logic [BW-1:0] x);
    logic [1:0]    d [0:3*M-3];
    logic [BW-1:0] r;
    for (int j = 0; j <= 3*M-3; j++)
      d[j] = 2'd0;
    for (int i = 0; i < M; i++)
      d[3*i] = x[2*i +: 2];
    for (int j = 3*M-3; j >= M; j--) begin
      d[j-M+12] = t_add(d[j-M+12], t_neg(d[j]));
      d[j-M]    = t_add(d[j-M], d[j]);
    end
    for (int i = 0; i < M; i++)
      r[2*i +: 2] = d[i];
    return r;
  endfunction

  // Tower: x^3 = x + 1, y^2 = -1.
  function automatic logic [`W6:0] f36m_cube(logic [`W6:0] x);
    logic [BW-1:0] f [0:5];
    logic [BW-1:0] r [0:5];
    for (int i = 0; i < 6; i++)
      f[i] = f3m_cube(x[i*BW +: BW]);
    r[0] = e_add(e_add(f[0], f[1]), f[2]);
    r[1] = e_add(f[1], e_neg(f[2]));
    r[2] = f[2];
    r[3] = e_neg(e_add(e_add(f[3], f[4]), f[5]));
    r[4] = e_neg(e_add(f[4], e_neg(f[5])));
    r[5] = e_neg(f[5]);
    return {r[5], r[4], r[3], r[2], r[1], r[0]};
  endfunction

  state_t        st, st_n;
  logic [`W6:0]  acc, cube;
  logic [KW-1:0] cnt, k, nx, nm;
  logic          mode_e;

  assign mode_e = EN_INV && mode;
  assign nx     = KW'(n);
  assign nm     = nx % K6M;
  assign cube   = f36m_cube(acc);

  always_comb begin
    k = nx;
    if (mode_e)
      k = (nm == '0) ? '0 : K6M - nm;
  end

  always_comb begin
    st_n = st;
    unique case (st)
      IDLE: if (start) st_n = (k == '0) ? DONE : RUN;
      RUN:  if (cnt == KW'(1)) st_n = DONE;
      DONE: st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  // c is loaded on the edge entering DONE so it is valid alongside done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st  <= IDLE;
      acc <= '0;
      cnt <= '0;
      c   <= '0;
    end else begin
      st <= st_n;
      unique case (st)
        IDLE: if (start) begin
          acc <= a;
          cnt <= k;
          if (k == '0) c <= a;
        end
        RUN: begin
          acc <= cube;
          cnt <= cnt - KW'(1);
          if (cnt == KW'(1)) c <= cube;
        end
        default: ;
      endcase
    end
  end

  assign busy = (st != IDLE);
  assign done = (st == DONE);

endmodule

// File: tb/tb_f36m_pow3_iter.sv
// Scoreboard bench for f36m_pow3_iter.
// Golden cube: per-coefficient x^(3i) table plus basis-cube matrix.
`ifndef W6
`define W6 1163
`endif

module tb_f36m_pow3_iter;

  localparam int M  = 97;
  localparam int BW = 2 * M;
  localparam int W  = `W6 + 1;

  typedef logic [`W6:0] elem_t;
  typedef struct {
    elem_t c;
    int    lat;
    int    t0;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] n = '0;
  elem_t      a = '0;
  logic       busy, done;
  elem_t      c;

  f36m_pow3_iter #(.CNT_W(8), .EN_INV(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .n(n), .a(a), .busy(busy), .done(done), .c(c)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   checks = 0, errors = 0, ndone = 0;
  exp_t sbq[$];
  int   T [0:M-1][0:M-1];
  int   B [0:5][0:5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input elem_t got, input elem_t exp);
    int fd;
    checks++;
    if (got !== exp) begin
      errors++;
      fd = -1;
      for (int i = 0; i < W; i++)
        if (fd < 0 && got[i] !== exp[i]) fd = i;
      $display("FAIL %s got=%h exp=%h (low128) first_diff_bit=%0d",
               tag, got[127:0], exp[127:0], fd);
    end
  endtask

  function automatic logic [11:0] tmul(logic [11:0] u, logic [11:0] v);
    int p [0:4][0:2];
    logic [11:0] r;
    for (int k = 0; k < 5; k++)
      for (int l = 0; l < 3; l++) p[k][l] = 0;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        p[i%3 + j%3][i/3 + j/3] += int'(u[2*i +: 2]) * int'(v[2*j +: 2]);
    for (int k = 0; k < 5; k++) p[k][0] -= p[k][2];
    for (int l = 0; l < 2; l++) begin
      p[2][l] += p[4][l]; p[1][l] += p[4][l];
      p[1][l] += p[3][l]; p[0][l] += p[3][l];
    end
    for (int k = 0; k < 3; k++)
      for (int l = 0; l < 2; l++)
        r[2*(k+3*l) +: 2] = 2'(((p[k][l] % 3) + 3) % 3);
    return r;
  endfunction

  function automatic logic [BW-1:0] bfrob(logic [BW-1:0] x);
    int acc [0:M-1];
    logic [BW-1:0] r;
    for (int j = 0; j < M; j++) acc[j] = 0;
    for (int i = 0; i < M; i++)
      if (x[2*i +: 2] != 2'd0)
        for (int j = 0; j < M; j++)
          acc[j] += int'(x[2*i +: 2]) * T[i][j];
    for (int j = 0; j < M; j++) r[2*j +: 2] = 2'(acc[j] % 3);
    return r;
  endfunction

  function automatic elem_t tcube(elem_t x);
    int acc [0:5][0:M-1];
    logic [BW-1:0] f;
    elem_t r;
    for (int m = 0; m < 6; m++)
      for (int q = 0; q < M; q++) acc[m][q] = 0;
    for (int j = 0; j < 6; j++) begin
      f = bfrob(x[j*BW +: BW]);
      for (int m = 0; m < 6; m++)
        if (B[j][m] != 0)
          for (int q = 0; q < M; q++)
            acc[m][q] += B[j][m] * int'(f[2*q +: 2]);
    end
    for (int m = 0; m < 6; m++)
      for (int q = 0; q < M; q++)
        r[m*BW + 2*q +: 2] = 2'(acc[m][q] % 3);
    return r;
  endfunction

  function automatic elem_t tcube_n(elem_t x, int k);
    elem_t r;
    r = x;
    for (int i = 0; i < k; i++) r = tcube(r);
    return r;
  endfunction

  function automatic elem_t rnd_elem();
    elem_t e;
    for (int i = 0; i < W/2; i++) e[2*i +: 2] = 2'($urandom_range(0, 2));
    return e;
  endfunction

  task automatic model_init();
    int p [0:M-1];
    int top;
    logic [11:0] e, cb;
    for (int j = 0; j < M; j++) p[j] = 0;
    p[0] = 1;
    for (int d = 0; d <= 3*(M-1); d++) begin
      if (d % 3 == 0)
        for (int j = 0; j < M; j++) T[d/3][j] = p[j];
      top = p[M-1];
      for (int j = M-1; j > 0; j--) p[j] = p[j-1];
      p[0]  = top;
      p[12] = (p[12] + 2*top) % 3;
    end
    for (int j = 0; j < 6; j++) begin
      e  = 12'd1 << (2*j);
      cb = tmul(tmul(e, e), e);
      for (int m = 0; m < 6; m++) B[j][m] = int'(cb[2*m +: 2]);
    end
  endtask

  always @(negedge clk) begin
    if (reset && ($isunknown(busy) || $isunknown(done)))
      chk("x_on_ctrl", elem_t'({busy, done}), '0);
    if (done === 1'b1) begin
      ndone++;
      if (sbq.size() == 0) begin
        chk("spurious_done", elem_t'(1), '0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result_c", c, e.c);
        chk("latency", elem_t'(cyc - e.t0 + 1), elem_t'(e.lat));
        chk("busy_at_done", elem_t'(busy), elem_t'(1));
      end
    end
  end

  task automatic wait_done(input int nd0, input int budget);
    for (int i = 0; i < budget && ndone == nd0; i++) begin
      @(negedge clk);
      #1;
    end
    if (ndone == nd0) chk("timeout", elem_t'(ndone), elem_t'(nd0 + 1));
  endtask

  task automatic go(input logic [7:0] nn, input logic md, input elem_t aa,
                    input elem_t ec, input int lat, input bit junk);
    int    nd0;
    elem_t hold;
    nd0 = ndone;
    @(negedge clk);
    n = nn; mode = md; a = aa; start = 1'b1;
    @(posedge clk);
    #1;
    sbq.push_back('{c: ec, lat: lat, t0: cyc});
    start = 1'b0;
    a = rnd_elem();
    n = 8'($urandom);
    hold = c;
    if (junk) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        #1;
        start = 1'b1;
        a = rnd_elem();
        n = 8'd0;
        chk("c_hold_run", c, hold);
      end
      @(negedge clk);
      start = 1'b0;
      #1;
    end
    wait_done(nd0, lat + 20);
  endtask

  elem_t ea, eb, e2, e4;
  int    nd0;

  initial begin
    model_init();
    ea = rnd_elem();
    e2 = rnd_elem();
    e4 = rnd_elem();
    #22;
    chk("rst_busy", elem_t'(busy), '0);
    chk("rst_done", elem_t'(done), '0);
    chk("rst_c", c, '0);
    @(negedge clk);
    reset = 1'b1;

    go(8'd0, 1'b0, ea, ea, 1, 1'b0);
    @(negedge clk);
    #1;
    chk("busy_after_k0", elem_t'(busy), '0);

    eb = tcube(ea);
    go(8'd1, 1'b0, ea, eb, 2, 1'b0);
    go(8'd3, 1'b0, ea, tcube_n(ea, 3), 4, 1'b1);
    go(8'd1, 1'b1, eb, ea, 582, 1'b0);
    go(8'd0, 1'b1, e2, e2, 1, 1'b0);
    go(8'd255, 1'b1, e2, tcube_n(e2, 327), 328, 1'b0);
    go(8'd255, 1'b0, e2, tcube_n(e2, 255), 256, 1'b0);

    // start held through DONE is taken only after the return to IDLE
    start = 1'b1; n = 8'd0; mode = 1'b0; a = e4;
    nd0 = ndone;
    @(posedge clk);
    #1;
    chk("b2b_ignored", elem_t'(busy), '0);
    @(posedge clk);
    #1;
    chk("b2b_taken", elem_t'(busy), elem_t'(1));
    sbq.push_back('{c: e4, lat: 1, t0: cyc});
    start = 1'b0;
    wait_done(nd0, 20);

    @(negedge clk);
    n = 8'd10; mode = 1'b0; a = ea; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", elem_t'(busy), '0);
    chk("abort_done", elem_t'(done), '0);
    chk("abort_c", c, '0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_nodone", elem_t'(done), '0);
      if (i == 2) reset = 1'b1;
    end
    go(8'd0, 1'b0, e4, e4, 1, 1'b0);

    repeat (3) @(negedge clk);
    chk("sbq_empty", elem_t'(sbq.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
